scan_index_sequencer: RTL and testbench
=======================================

# scan_index_sequencer

Timed index generator that drives the 2-bit select pair `{a, b}` of the downstream 2-to-4 one-hot decoder. It steps the index 0→1→2→3 with a programmable dwell per index, in single-sweep or continuous mode. Its outputs connect directly to the decoder's `a`/`b` inputs, and its `step`/`done` pulses go to control logic. Typical uses are display-digit scanning and round-robin channel enable.

## Interface

- `DW`, default 16: width of the dwell count.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep when the block is idle; ignored while busy.
- `stop`  in  1  aborts the sweep in progress.
- `mode_cont`  in  1  1 = continuous (wraps 3→0), 0 = single sweep. Sampled with `start`.
- `dwell`  in  DW  each index is held for `dwell`+1 cycles. Sampled with `start`.
- `a`  out  1  index MSB, to decoder input `a`.
- `b`  out  1  index LSB, to decoder input `b`.
- `busy`  out  1  high while a sweep is in progress.
- `step`  out  1  one-cycle pulse, aligned with each new index value, including the first.
- `done`  out  1  one-cycle pulse when a single sweep completes normally.

## Operation

- Two states: IDLE and SCAN. Internal registers:
  - 2-bit index `idx`; `{a, b}` = `idx`.
  - DW-bit counter `cnt`.
  - Latched `dwell_q` and `cont_q`.
- **Reset:**
  - State goes to IDLE.
  - `a`=0, `b`=0, `busy`=0, `step`=0, `done`=0, `cnt`=0.
  - `dwell_q`=0, `cont_q`=0.
- **IDLE:**
  - `{a,b}` held at 00; `busy`=0.
  - If `start`=1 and `stop`=0, go to SCAN on the next edge, and at that edge:
    - latch `dwell_q`=`dwell` and `cont_q`=`mode_cont`;
    - set `idx`=0, `cnt`=0, `busy`=1, `step`=1.
- **SCAN,** one of the following at each edge, in priority order:
  - `stop`=1: go to IDLE. `idx`=0, `busy`=0, no `done`, no `step`.
  - `cnt` ≠ `dwell_q`: `cnt`+1.
  - `cnt` = `dwell_q` and `idx` < 3: `idx`+1, `cnt`=0, `step`=1.
  - `cnt` = `dwell_q`, `idx` = 3, `cont_q`=1: `idx`=0, `cnt`=0, `step`=1 (wrap).
  - `cnt` = `dwell_q`, `idx` = 3, `cont_q`=0: go to IDLE. `idx`=0, `busy`=0, `done`=1, no `step`.
- **Changes during a sweep:**
  - `start` is ignored while in SCAN.
  - Changes on `dwell` or `mode_cont` have no effect until the next accepted `start`.
- `step` and `done` are registered and last exactly one cycle. They are never high in the same cycle.
- **Arithmetic:**
  - `cnt` compares for equality against `dwell_q` only; it never wraps.
  - `dwell`=0 gives 1 cycle per index. `dwell`=2^DW−1 gives 2^DW cycles per index.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Latency from `start` sampled at edge E0:
  - `busy`=1, `{a,b}`=00 and `step`=1 are visible after E0.
- Each index is held for exactly `dwell_q`+1 cycles.
- Single sweep:
  - `busy` is high for exactly 4·(`dwell_q`+1) cycles.
  - `done` pulses in the first cycle after `busy` falls, and `{a,b}` returns to 00 in that same cycle.
- Continuous sweep:
  - The period is 4·(`dwell_q`+1) cycles.
  - `step` fires at every index change, including the 3→0 wrap.
- `stop` at edge E: IDLE after E. No partial dwell is completed.
- `start` with `stop` in the same cycle while in IDLE: `stop` wins and the block remains in IDLE.
- `start` in the same cycle that `done` is produced: ignored, because the block is still in SCAN at that edge.
- `rst` during SCAN: reset values after that edge. No `done`, no `step`. `rst` overrides all other inputs.

## Test plan

- Reset, then `start` with `dwell`=0 and `mode_cont`=0:
  - `{a,b}` = 00, 01, 10, 11 on four consecutive cycles, with `step` high in each of those cycles.
  - `busy` high for 4 cycles.
  - `done`=1 on the 5th cycle, with `{a,b}`=00.
- `dwell`=2, `mode_cont`=1, `start`:
  - Each index held 3 cycles; the 3→0 wrap produces `step`.
  - No `done` after 3 full periods (36 cycles).
- Continuous sweep at `idx`=2 with `cnt`=1, assert `stop`:
  - Next cycle `busy`=0, `{a,b}`=00, `done`=0, `step`=0.
- During a single sweep with `dwell`=3:
  - Pulse `start` and set `dwell`=0, `mode_cont`=1.
  - Required: the sweep continues unchanged at 4 cycles per index and ends with a single `done`.
- Assert `rst` mid-sweep at `idx`=1:
  - Next cycle all outputs are 0 and the block is in IDLE.
  - A later `start` begins cleanly at `idx` 0.
- In IDLE, assert `start` and `stop` in the same cycle: the block remains in IDLE with `busy`=0.
- With DW=4 and `dwell`=15: each index held 16 cycles and `busy` is high for 64 cycles.

Source files
------------

// File: rtl/scan_index_sequencer.sv
// -----------------------------------------------------------------------------
// scan_index_sequencer
//
// Timed index generator for the 2-bit select pair {a, b} of a downstream
// 2-to-4 one-hot decoder. It steps the index 0->1->2->3. Each index is held
// for dwell+1 cycles. The block runs one sweep or wraps continuously.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset, overrides everything
//   start      in   1   begin a sweep when idle (ignored while busy)
//   stop       in   1   abort the sweep in progress (wins over start)
//   mode_cont  in   1   1 = continuous wrap 3->0, 0 = single sweep
//   dwell      in   DW  per-index hold is dwell+1 cycles
//   a          out  1   index MSB
//   b          out  1   index LSB
//   busy       out  1   high while a sweep is in progress
//   step       out  1   one-cycle pulse with every new index value
//   done       out  1   one-cycle pulse after a single sweep completes
//
// mode_cont and dwell are captured only when start is accepted. All outputs
// come straight from flops.
// -----------------------------------------------------------------------------
module scan_index_sequencer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          mode_cont,
  input  logic [DW-1:0] dwell,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          step,
  output logic          done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  state_t        state_r, state_s;
  logic [1:0]    idx_r,   idx_s;
  logic [DW-1:0] cnt_r,   cnt_s;
  logic [DW-1:0] dwell_r, dwell_s;
  logic          cont_r,  cont_s;
  logic          busy_r,  busy_s;
  logic          step_r,  step_s;
  logic          done_r,  done_s;

  // State and output registers; the reset has priority over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'b00;
      cnt_r   <= CNT_ZERO;
      dwell_r <= CNT_ZERO;
      cont_r  <= 1'b0;
      busy_r  <= 1'b0;
      step_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      dwell_r <= dwell_s;
      cont_r  <= cont_s;
      busy_r  <= busy_s;
      step_r  <= step_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic and next output values.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    dwell_s = dwell_r;
    cont_s  = cont_r;
    busy_s  = busy_r;
    step_s  = 1'b0;
    done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        idx_s  = 2'b00;
        busy_s = 1'b0;
        if (start && !stop) begin
          // Settings are frozen here and ignored for the rest of the sweep.
          state_s = ST_SCAN;
          dwell_s = dwell;
          cont_s  = mode_cont;
          cnt_s   = CNT_ZERO;
          busy_s  = 1'b1;
          step_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (stop) begin
          // Abort: drop straight back to idle without finishing the dwell.
          state_s = ST_IDLE;
          idx_s   = 2'b00;
          busy_s  = 1'b0;
        end else if (cnt_r != dwell_r) begin
          cnt_s = cnt_r + CNT_ONE;
        end else if (idx_r != 2'd3) begin
          idx_s  = idx_r + 2'd1;
          cnt_s  = CNT_ZERO;
          step_s = 1'b1;
        end else if (cont_r) begin
          idx_s  = 2'b00;
          cnt_s  = CNT_ZERO;
          step_s = 1'b1;
        end else begin
          // The last dwell of a single sweep has ended.
          state_s = ST_IDLE;
          idx_s   = 2'b00;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        idx_s   = 2'b00;
        cnt_s   = CNT_ZERO;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign a    = idx_r[1];
  assign b    = idx_r[0];
  assign busy = busy_r;
  assign step = step_r;
  assign done = done_r;

endmodule

// File: tb/tb_scan_index_sequencer.sv
module tb_scan_index_sequencer;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode_cont = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          a, b, busy, step, done;

  int n_cmp = 0;
  int n_err = 0;

  scan_index_sequencer #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mode_cont(mode_cont), .dwell(dwell),
    .a(a), .b(b), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a sweep is described by its elapsed cycle count since the
  // accepted start. The index and step are derived arithmetically from it.
  logic m_act = 1'b0;
  logic m_done = 1'b0;
  logic m_c = 1'b0;
  int   m_k = 0;
  int   m_d = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
      m_d    <= 0;
      m_c    <= 1'b0;
    end else if (m_act) begin
      m_done <= 1'b0;
      if (stop) m_act <= 1'b0;
      else if (!m_c && (m_k + 1) == 4 * (m_d + 1)) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
      end else m_k <= m_k + 1;
    end else begin
      m_done <= 1'b0;
      if (start && !stop) begin
        m_act <= 1'b1;
        m_k   <= 0;
        m_d   <= int'(dwell);
        m_c   <= mode_cont;
      end
    end
  end

  logic [4:0] dut_out, exp_out;
  logic [1:0] exp_idx;
  assign dut_out = {a, b, busy, step, done};

  always_comb begin
    exp_idx = 2'((m_k / (m_d + 1)) % 4);
    if (m_act) exp_out = {exp_idx, 1'b1, ((m_k % (m_d + 1)) == 0), 1'b0};
    else       exp_out = {4'b0000, m_done};
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_out !== 5'b00000) begin
      n_err++;
      $display("FAIL reset got=%b exp=%b", dut_out, 5'b00000);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_dwell0();
    logic [4:0] want;
    int nbusy;
    nbusy = 0;
    dwell = 4'd0; mode_cont = 1'b0; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 4)       want = {2'(i), 1'b1, 1'b1, 1'b0};
      else if (i == 4) want = 5'b00001;
      else             want = 5'b00000;
      if (busy) nbusy++;
      n_cmp++;
      if (dut_out !== want) begin
        n_err++;
        $display("FAIL single_d0 cyc=%0d got=%b exp=%b", i, dut_out, want);
      end
    end
    n_cmp++;
    if (nbusy != 4) begin
      n_err++;
      $display("FAIL single_d0_busylen got=%0d exp=4", nbusy);
    end
  endtask

  task automatic test_cont_and_stop();
    int nstep, ndone;
    nstep = 0; ndone = 0;
    dwell = 4'd2; mode_cont = 1'b1; start = 1'b1;
    // Observations k=0..43; k=43 is idx 2 with cnt 1 of the 4th period.
    for (int i = 0; i < 44; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (step) nstep++;
      if (done) ndone++;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL cont cyc=%0d got=%b exp=%b", i, dut_out, exp_out);
      end
    end
    n_cmp++;
    if (nstep != 15 || ndone != 0) begin
      n_err++;
      $display("FAIL cont_counts got step=%0d done=%0d exp step=15 done=0", nstep, ndone);
    end
    n_cmp++;
    if ({a, b} !== 2'b10) begin
      n_err++;
      $display("FAIL cont_pre_stop_idx got=%b exp=10", {a, b});
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    n_cmp++;
    if (dut_out !== 5'b00000) begin
      n_err++;
      $display("FAIL stop got=%b exp=%b", dut_out, 5'b00000);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL stop_idle got=%b exp=%b", dut_out, exp_out);
      end
    end
  endtask

  task automatic test_ignore_changes();
    int nbusy, nstep, ndone;
    nbusy = 0; nstep = 0; ndone = 0;
    dwell = 4'd3; mode_cont = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      // i==15 drives start into the very edge that produces done.
      start = (i == 5) || (i == 15);
      if (i == 5) begin
        dwell = 4'd0; mode_cont = 1'b1;
      end
      if (busy) nbusy++;
      if (step) nstep++;
      if (done) ndone++;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL ignore cyc=%0d got=%b exp=%b", i, dut_out, exp_out);
      end
    end
    n_cmp++;
    if (nbusy != 16 || nstep != 4 || ndone != 1) begin
      n_err++;
      $display("FAIL ignore_counts got busy=%0d step=%0d done=%0d exp 16/4/1", nbusy, nstep, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    d = int'($urandom_range(1, 15));
    dwell = 4'(d); mode_cont = 1'($urandom_range(0, 1)); start = 1'b1;
    for (int i = 0; i <= d + 1; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL rstmid_run cyc=%0d got=%b exp=%b", i, dut_out, exp_out);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (dut_out !== 5'b00000) begin
      n_err++;
      $display("FAIL rstmid got=%b exp=%b", dut_out, 5'b00000);
    end
    dwell = 4'd0; mode_cont = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (dut_out !== 5'b00110) begin
      n_err++;
      $display("FAIL rstmid_restart got=%b exp=%b", dut_out, 5'b00110);
    end
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL rstmid_after got=%b exp=%b", dut_out, exp_out);
      end
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; dwell = 4'd1; mode_cont = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    n_cmp++;
    if (dut_out !== 5'b00000) begin
      n_err++;
      $display("FAIL start_stop got=%b exp=%b", dut_out, 5'b00000);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_hold got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_max_dwell();
    int nbusy, nstep, ndone;
    nbusy = 0; nstep = 0; ndone = 0;
    dwell = 4'd15; mode_cont = 1'b0; start = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) nbusy++;
      if (step) nstep++;
      if (done) ndone++;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL maxdwell cyc=%0d got=%b exp=%b", i, dut_out, exp_out);
      end
    end
    n_cmp++;
    if (nbusy != 64 || nstep != 4 || ndone != 1) begin
      n_err++;
      $display("FAIL maxdwell_counts got busy=%0d step=%0d done=%0d exp 64/4/1", nbusy, nstep, ndone);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      dwell     = 4'($urandom_range(0, 15));
      mode_cont = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_cmp++;
      if (dut_out !== exp_out) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_out, exp_out);
      end
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_dwell0();
    test_cont_and_stop();
    test_ignore_changes();
    test_reset_mid();
    test_start_stop();
    test_max_dwell();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
